// File: rtl/vex_shim_pkg.sv
// Shared types and helpers for the vex ingress shim: stream word layout, pointer sizing, defaults.
// Types only, so there is no latency and no backpressure.
package vex_shim_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DROP_W_DEF = 16;

    typedef struct packed {
        logic                  last;
        logic [DATA_W_DEF-1:0] data;
    } stream_word_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/vex_shim_fifo.sv
// Synchronous first-word-fall-through FIFO. A write is visible on rd_dat one edge later.
// Writes are refused when full unless a read happens in the same cycle; reads are ignored when empty.
module vex_shim_fifo
    import vex_shim_pkg::*;
#(
    parameter int W     = 33,
    parameter int DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic [W-1:0]        wr_dat,
    output logic                wr_acc,
    input  logic                rd_en,
    output logic [W-1:0]        rd_dat,
    output logic                full,
    output logic                empty,
    output logic [ptr_w(DEPTH):0] count
);

    localparam int AW = ptr_w(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [W-1:0]  mem [DEPTH];
    logic          rd_acc;

    // The extra pointer MSB tells full from empty when the low bits match.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count  = wr_ptr - rd_ptr;
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);
    assign rd_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
        end
    end

endmodule

// File: rtl/vex_ingress_shim.sv
// Stream ingress front end: buffers an unstallable upstream (or a counter source) into a valid/ready stream.
// One cycle write-to-valid; upstream is never stalled, so overflow drops words and counts them; ringbus is RB_STAGES flops.
module vex_ingress_shim
    import vex_shim_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int RB_STAGES    = 1,
    parameter int COUNTER_MODE = 0,
    parameter int FRAME_LEN    = 64,
    parameter int DROP_W       = DROP_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [DATA_W-1:0]          t0_data,
    input  logic                       t0_last,
    input  logic                       t0_valid,
    output logic                       t0_ready,
    output logic [DATA_W-1:0]          i0_data,
    output logic                       i0_last,
    output logic                       i0_valid,
    input  logic                       i0_ready,
    output logic [ptr_w(FIFO_DEPTH):0] fill_level,
    output logic [DROP_W-1:0]          drop_count,
    output logic                       overflow_sticky,
    input  logic                       clear_stats,
    input  logic                       i_ringbus,
    output logic                       o_ringbus,
    output logic                       rb_to_engine,
    input  logic                       rb_from_engine
);

    localparam int LW = $clog2(FRAME_LEN);

    logic              full;
    logic              empty;
    logic              rd;
    logic              wr_req;
    logic              wr_acc;
    logic              drop;
    logic              cnt_last;
    logic [DATA_W:0]   wr_dat;
    logic [DATA_W:0]   rd_dat;
    logic [DATA_W-1:0] cnt_q;
    logic [RB_STAGES-1:0] rb_in_q;
    logic [RB_STAGES-1:0] rb_out_q;

    assign t0_ready = 1'b1;
    assign i0_valid = !empty;
    assign rd       = i0_valid && i0_ready;
    assign {i0_last, i0_data} = rd_dat;

    assign cnt_last = &cnt_q[LW-1:0];

    always_comb begin
        wr_req = t0_valid;
        wr_dat = {t0_last, t0_data};
        if (COUNTER_MODE != 0) begin
            wr_req = !full;
            wr_dat = {cnt_last, cnt_q};
        end
    end

    // A read in the same cycle frees a slot, so only full-without-read loses the word.
    assign drop = (COUNTER_MODE == 0) && t0_valid && full && !rd;

    vex_shim_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_req),
        .wr_dat  (wr_dat),
        .wr_acc  (wr_acc),
        .rd_en   (i0_ready),
        .rd_dat  (rd_dat),
        .full    (full),
        .empty   (empty),
        .count   (fill_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (wr_acc && (COUNTER_MODE != 0)) begin
            cnt_q <= cnt_q + DATA_W'(1);
        end
    end

    // Clear takes effect first; a drop in the same cycle then counts from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count      <= '0;
            overflow_sticky <= 1'b0;
        end else if (clear_stats) begin
            drop_count      <= drop ? DROP_W'(1) : '0;
            overflow_sticky <= drop;
        end else if (drop) begin
            if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
            overflow_sticky <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rb_in_q  <= '0;
            rb_out_q <= '0;
        end else begin
            rb_in_q[0]  <= i_ringbus;
            rb_out_q[0] <= rb_from_engine;
            for (int k = 1; k < RB_STAGES; k++) begin
                rb_in_q[k]  <= rb_in_q[k-1];
                rb_out_q[k] <= rb_out_q[k-1];
            end
        end
    end

    assign rb_to_engine = rb_in_q[RB_STAGES-1];
    assign o_ringbus    = rb_out_q[RB_STAGES-1];

endmodule

// File: tb/tb_vex_ingress_shim.sv
// Bench for vex_ingress_shim: a pass-through instance (RB_STAGES=3) and a counter-mode instance (FRAME_LEN=4).
module tb_vex_ingress_shim;
    import vex_shim_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [31:0] t0_data;
    logic        t0_last, t0_valid, t0_ready;
    logic [31:0] i0_data;
    logic        i0_last, i0_valid, i0_ready;
    logic [4:0]  fill_level;
    logic [15:0] drop_count;
    logic        overflow_sticky, clear_stats;
    logic        i_ringbus, o_ringbus, rb_to_engine, rb_from_engine;

    logic        c_t0_ready;
    logic [31:0] c_i0_data;
    logic        c_i0_last, c_i0_valid, c_i0_ready;
    logic [4:0]  c_fill_level;
    logic [15:0] c_drop_count;
    logic        c_overflow_sticky, c_o_ringbus, c_rb_to_engine;

    int total = 0;
    int bad   = 0;
    stream_word_t exp_q[$];
    stream_word_t e;

    vex_ingress_shim #(
        .DATA_W(32), .FIFO_DEPTH(16), .RB_STAGES(3), .COUNTER_MODE(0), .FRAME_LEN(64), .DROP_W(16)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .t0_data(t0_data), .t0_last(t0_last), .t0_valid(t0_valid), .t0_ready(t0_ready),
        .i0_data(i0_data), .i0_last(i0_last), .i0_valid(i0_valid), .i0_ready(i0_ready),
        .fill_level(fill_level), .drop_count(drop_count), .overflow_sticky(overflow_sticky),
        .clear_stats(clear_stats), .i_ringbus(i_ringbus), .o_ringbus(o_ringbus),
        .rb_to_engine(rb_to_engine), .rb_from_engine(rb_from_engine)
    );

    vex_ingress_shim #(
        .DATA_W(32), .FIFO_DEPTH(16), .RB_STAGES(1), .COUNTER_MODE(1), .FRAME_LEN(4), .DROP_W(16)
    ) dut_cnt (
        .clk(clk), .reset_n(reset_n),
        .t0_data(t0_data), .t0_last(t0_last), .t0_valid(t0_valid), .t0_ready(c_t0_ready),
        .i0_data(c_i0_data), .i0_last(c_i0_last), .i0_valid(c_i0_valid), .i0_ready(c_i0_ready),
        .fill_level(c_fill_level), .drop_count(c_drop_count), .overflow_sticky(c_overflow_sticky),
        .clear_stats(1'b0), .i_ringbus(1'b0), .o_ringbus(c_o_ringbus),
        .rb_to_engine(c_rb_to_engine), .rb_from_engine(1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset_n = 1'b0; t0_data = '0; t0_last = 1'b0; t0_valid = 1'b0;
        i0_ready = 1'b0; c_i0_ready = 1'b0; clear_stats = 1'b0;
        i_ringbus = 1'b0; rb_from_engine = 1'b0;
        #3;
        total++; if (t0_ready !== 1'b1) begin bad++; $display("FAIL reset_t0_ready got=%b want=1", t0_ready); end
        total++; if (i0_valid !== 1'b0) begin bad++; $display("FAIL reset_i0_valid got=%b want=0", i0_valid); end
        total++; if (i0_data !== 32'h0 || i0_last !== 1'b0) begin bad++; $display("FAIL reset_i0_word got=%b/%h want=0/0", i0_last, i0_data); end
        total++; if (fill_level !== 5'd0) begin bad++; $display("FAIL reset_fill got=%0d want=0", fill_level); end
        total++; if (drop_count !== 16'd0 || overflow_sticky !== 1'b0) begin bad++; $display("FAIL reset_stats got=%0d/%b want=0/0", drop_count, overflow_sticky); end
        total++; if (o_ringbus !== 1'b0 || rb_to_engine !== 1'b0) begin bad++; $display("FAIL reset_ringbus got=%b/%b want=0/0", o_ringbus, rb_to_engine); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_passthrough();
        int popped  = 0;
        int first_v = -1;
        i0_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (i < 10) begin
                t0_valid = 1'b1; t0_data = 32'(i + 1); t0_last = (i == 9);
                exp_q.push_back(stream_word_t'({t0_last, t0_data}));
            end else begin
                t0_valid = 1'b0; t0_last = 1'b0;
            end
            @(negedge clk);
            if (i0_valid && first_v < 0) first_v = i;
            if (i0_valid && i0_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL pass_extra got=%b/%h want=none", i0_last, i0_data); end
                else begin
                    e = exp_q.pop_front();
                    if ({i0_last, i0_data} !== e) begin bad++; $display("FAIL pass_word got=%b/%h want=%b/%h", i0_last, i0_data, e.last, e.data); end
                end
                popped++;
            end
        end
        total++; if (first_v != 1) begin bad++; $display("FAIL pass_latency got=%0d want=1", first_v); end
        total++; if (popped != 10) begin bad++; $display("FAIL pass_count got=%0d want=10", popped); end
    endtask

    task automatic test_overflow();
        int popped = 0;
        i0_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            t0_valid = 1'b1; t0_data = 32'(i + 1); t0_last = 1'b0;
            if (i < 16) exp_q.push_back(stream_word_t'({t0_last, t0_data}));
        end
        @(posedge clk); #1 t0_valid = 1'b0;
        @(negedge clk);
        total++; if (fill_level !== 5'd16) begin bad++; $display("FAIL ovf_fill got=%0d want=16", fill_level); end
        total++; if (drop_count !== 16'd4) begin bad++; $display("FAIL ovf_drops got=%0d want=4", drop_count); end
        total++; if (overflow_sticky !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow_sticky); end
        total++; if (i0_valid !== 1'b1 || i0_data !== 32'h1) begin bad++; $display("FAIL ovf_hold got=%b/%h want=1/1", i0_valid, i0_data); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1 i0_ready = 1'b1;
            @(negedge clk);
            if (i0_valid && i0_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL ovf_extra got=%h want=none", i0_data); end
                else begin
                    e = exp_q.pop_front();
                    if ({i0_last, i0_data} !== e) begin bad++; $display("FAIL ovf_word got=%b/%h want=%b/%h", i0_last, i0_data, e.last, e.data); end
                end
                popped++;
            end
        end
        total++; if (popped != 16) begin bad++; $display("FAIL ovf_drain got=%0d want=16", popped); end
        total++; if (fill_level !== 5'd0) begin bad++; $display("FAIL ovf_empty got=%0d want=0", fill_level); end
    endtask

    task automatic test_full_rw();
        @(posedge clk); #1 clear_stats = 1'b1;
        @(posedge clk); #1 clear_stats = 1'b0;
        @(negedge clk);
        total++; if (drop_count !== 16'd0 || overflow_sticky !== 1'b0) begin bad++; $display("FAIL clr_stats got=%0d/%b want=0/0", drop_count, overflow_sticky); end
        i0_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            t0_valid = 1'b1; t0_data = 32'h100 + 32'(i); t0_last = (i == 15);
            exp_q.push_back(stream_word_t'({t0_last, t0_data}));
        end
        @(posedge clk); #1 t0_valid = 1'b0;
        @(negedge clk);
        total++; if (fill_level !== 5'd16) begin bad++; $display("FAIL frw_prefill got=%0d want=16", fill_level); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            i0_ready = 1'b1; t0_valid = 1'b1; t0_data = 32'h200 + 32'(i); t0_last = 1'b0;
            exp_q.push_back(stream_word_t'({t0_last, t0_data}));
            @(negedge clk);
            total++; if (fill_level !== 5'd16) begin bad++; $display("FAIL frw_fill got=%0d want=16", fill_level); end
            if (i0_valid && i0_ready) begin
                total++;
                e = exp_q.pop_front();
                if ({i0_last, i0_data} !== e) begin bad++; $display("FAIL frw_word got=%b/%h want=%b/%h", i0_last, i0_data, e.last, e.data); end
            end
        end
        @(posedge clk); #1 t0_valid = 1'b0;
        @(negedge clk);
        total++; if (fill_level !== 5'd16 || drop_count !== 16'd0) begin bad++; $display("FAIL frw_nodrop got=%0d/%0d want=16/0", fill_level, drop_count); end
        for (int i = 0; i < 40; i++) begin
            if (i0_valid && i0_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL frw_extra got=%h want=none", i0_data); end
                else begin
                    e = exp_q.pop_front();
                    if ({i0_last, i0_data} !== e) begin bad++; $display("FAIL frw_drain got=%b/%h want=%b/%h", i0_last, i0_data, e.last, e.data); end
                end
            end
            @(negedge clk);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL frw_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_ringbus();
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            i_ringbus      = (k == 0);
            rb_from_engine = (k == 1);
            @(negedge clk);
            total++; if (rb_to_engine !== (k == 3)) begin bad++; $display("FAIL rb_in k=%0d got=%b want=%b", k, rb_to_engine, (k == 3)); end
            total++; if (o_ringbus !== (k == 4)) begin bad++; $display("FAIL rb_out k=%0d got=%b want=%b", k, o_ringbus, (k == 4)); end
        end
    endtask

    task automatic test_counter();
        logic [31:0] nxt = 32'd0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            c_i0_ready = (i < 12) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (c_i0_valid && c_i0_ready) begin
                total++;
                if (c_i0_data !== nxt || c_i0_last !== (nxt[1:0] == 2'd3)) begin
                    bad++; $display("FAIL cnt_word got=%b/%h want=%b/%h", c_i0_last, c_i0_data, (nxt[1:0] == 2'd3), nxt);
                end
                nxt = nxt + 32'd1;
            end
        end
        total++; if (nxt < 32'd20) begin bad++; $display("FAIL cnt_progress got=%0d want>=20", nxt); end
        total++; if (c_drop_count !== 16'd0) begin bad++; $display("FAIL cnt_drops got=%0d want=0", c_drop_count); end
    endtask

    task automatic test_reset_mid();
        i0_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            t0_valid = 1'b1; t0_data = 32'h300 + 32'(i); t0_last = 1'b0;
        end
        @(posedge clk); #1 t0_valid = 1'b0;
        @(negedge clk);
        total++; if (fill_level !== 5'd5) begin bad++; $display("FAIL rst_prefill got=%0d want=5", fill_level); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (i0_valid !== 1'b0 || i0_data !== 32'h0) begin bad++; $display("FAIL rst_async_out got=%b/%h want=0/0", i0_valid, i0_data); end
        total++; if (fill_level !== 5'd0 || drop_count !== 16'd0) begin bad++; $display("FAIL rst_async_stats got=%0d/%0d want=0/0", fill_level, drop_count); end
        #10 reset_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        total++; if (i0_valid !== 1'b0) begin bad++; $display("FAIL rst_no_partial got=%b want=0", i0_valid); end
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            t0_valid = 1'b1; t0_data = 32'h400 + 32'(i);
        end
        @(posedge clk); #1 t0_valid = 1'b0;
        @(negedge clk);
        total++; if (drop_count !== 16'd2) begin bad++; $display("FAIL rst_predrop got=%0d want=2", drop_count); end
        @(posedge clk); #1 t0_valid = 1'b1; clear_stats = 1'b1;
        @(posedge clk); #1 t0_valid = 1'b0; clear_stats = 1'b0;
        @(negedge clk);
        total++; if (drop_count !== 16'd1 || overflow_sticky !== 1'b1) begin bad++; $display("FAIL clr_drop got=%0d/%b want=1/1", drop_count, overflow_sticky); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_overflow();
        test_full_rw();
        test_ringbus();
        test_counter();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
